// File: rtl/lcd_number_writer_if.sv
// Bus bundle between the BCD number source and the HD44780 LCD writer.
// The master side supplies the value and refresh requests and watches the LCD pins.
// The slave side is the writer, which drives the LCD pins and the status flags.
interface lcd_number_writer_if;
  logic       sinal;
  logic [3:0] dezena_milhar;
  logic [3:0] milhar;
  logic [3:0] centena;
  logic [3:0] dezena;
  logic [3:0] unidade;
  logic       refresh;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_en;
  logic       lcd_rw;
  logic       busy;
  logic       done;

  modport master (
    output sinal, dezena_milhar, milhar, centena, dezena, unidade, refresh,
    input  lcd_data, lcd_rs, lcd_en, lcd_rw, busy, done
  );

  modport slave (
    input  sinal, dezena_milhar, milhar, centena, dezena, unidade, refresh,
    output lcd_data, lcd_rs, lcd_en, lcd_rw, busy, done
  );
endinterface

// File: rtl/lcd_number_writer.sv
// Drives a write-only 8-bit HD44780 16x2 LCD with a signed 5-digit BCD value.
// After reset it waits for LCD power-up and runs the init commands once. It then
// rewrites the display ("+01234" / "-32768") whenever the value changes or a
// refresh is requested.
// Every byte is one transaction: a setup cycle, then an enable-high phase, then an
// enable-low wait. The LCD latches the byte on the falling edge of enable.
module lcd_number_writer #(
  parameter int PWR_WAIT  = 750_000,
  parameter int EN_CYCLES = 25,
  parameter int CMD_WAIT  = 100_000,
  parameter int CLR_WAIT  = 200_000
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_number_writer_if.slave bus
);

  // The counter is sized for the longest interval it has to time, so it cannot wrap.
  localparam int MAX_A = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
  localparam int MAX_B = (MAX_A > CMD_WAIT) ? MAX_A : CMD_WAIT;
  localparam int MAX_C = (MAX_B > EN_CYCLES) ? MAX_B : EN_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_UPD, S_DONE} state_t;
  typedef enum logic [1:0] {P_SETUP, P_EN, P_WAIT} phase_t;

  state_t        r_state, w_state_next;
  phase_t        r_phase, w_phase_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_idx, w_idx_next;
  logic [7:0]    r_data, w_data_next;
  logic          r_rs, w_rs_next;
  logic [20:0]   r_shown, w_shown_next;
  logic          r_shown_vld, w_shown_vld_next;
  logic          r_pend, w_pend_next;
  logic          w_snap;
  logic [CW-1:0] w_wait_last;
  logic [20:0]   w_in;

  // The value as {sign, ten-thousands, thousands, hundreds, tens, units}.
  assign w_in = {bus.sinal, bus.dezena_milhar, bus.milhar, bus.centena, bus.dezena, bus.unidade};

  // A clear command needs the long settle time; every other byte uses the short one.
  assign w_wait_last = (r_data == 8'h01 && !r_rs) ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);

  // Maps a BCD digit to ASCII. Non-decimal codes show up as '?' so that bad input is visible.
  function automatic logic [7:0] f_digit(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
  endfunction

  // Power-on command list: 8-bit/2-line, display on/cursor off, entry increment, clear.
  function automatic logic [7:0] f_init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // Update list: clear, sign, then the five digits from most to least significant.
  function automatic logic [7:0] f_upd_byte(input logic [2:0] idx, input logic [20:0] v);
    case (idx)
      3'd1:    return v[20] ? 8'h2D : 8'h2B;
      3'd2:    return f_digit(v[19:16]);
      3'd3:    return f_digit(v[15:12]);
      3'd4:    return f_digit(v[11:8]);
      3'd5:    return f_digit(v[7:4]);
      3'd6:    return f_digit(v[3:0]);
      default: return 8'h01;
    endcase
  endfunction

  // State register. Reset also drops lcd_en at once, because enable is decoded from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PWR;
      r_phase     <= P_SETUP;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_shown     <= '0;
      r_shown_vld <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_cnt       <= w_cnt_next;
      r_idx       <= w_idx_next;
      r_data      <= w_data_next;
      r_rs        <= w_rs_next;
      r_shown     <= w_shown_next;
      r_shown_vld <= w_shown_vld_next;
      r_pend      <= w_pend_next;
    end
  end

  // Next-state logic: sequence the power wait, the init list, update detection and the byte transactions.
  always_comb begin
    w_state_next     = r_state;
    w_phase_next     = r_phase;
    w_cnt_next       = r_cnt;
    w_idx_next       = r_idx;
    w_data_next      = r_data;
    w_rs_next        = r_rs;
    w_shown_next     = r_shown;
    w_shown_vld_next = r_shown_vld;
    w_pend_next      = r_pend;
    w_snap           = 1'b0;

    // Refresh requests are remembered outside power-up/init. Several of them collapse into one.
    if (bus.refresh && r_state != S_PWR && r_state != S_INIT)
      w_pend_next = 1'b1;

    case (r_state)
      S_PWR: begin
        if (r_cnt == CW'(PWR_WAIT - 1)) begin
          w_state_next = S_INIT;
          w_idx_next   = 3'd0;
          w_phase_next = P_SETUP;
          w_cnt_next   = '0;
          w_data_next  = f_init_byte(3'd0);
          w_rs_next    = 1'b0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_INIT, S_UPD: begin
        case (r_phase)
          P_SETUP: begin
            w_phase_next = P_EN;
            w_cnt_next   = '0;
          end
          P_EN: begin
            if (r_cnt == CW'(EN_CYCLES - 1)) begin
              w_phase_next = P_WAIT;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
          default: begin
            if (r_cnt == w_wait_last) begin
              w_cnt_next   = '0;
              w_phase_next = P_SETUP;
              if (r_state == S_INIT) begin
                if (r_idx == 3'd3) begin
                  w_snap = 1'b1;
                end else begin
                  w_idx_next  = r_idx + 3'd1;
                  w_data_next = f_init_byte(r_idx + 3'd1);
                  w_rs_next   = 1'b0;
                end
              end else begin
                if (r_idx == 3'd6) begin
                  w_state_next = S_DONE;
                end else begin
                  w_idx_next  = r_idx + 3'd1;
                  w_data_next = f_upd_byte(r_idx + 3'd1, r_shown);
                  w_rs_next   = 1'b1;
                end
              end
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
        endcase
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        if (!r_shown_vld || w_in != r_shown || r_pend)
          w_snap = 1'b1;
      end
    endcase

    // Entering an update freezes the value. Input changes after this point wait for the next IDLE.
    if (w_snap) begin
      w_state_next     = S_UPD;
      w_idx_next       = 3'd0;
      w_phase_next     = P_SETUP;
      w_cnt_next       = '0;
      w_data_next      = 8'h01;
      w_rs_next        = 1'b0;
      w_shown_next     = w_in;
      w_shown_vld_next = 1'b1;
      w_pend_next      = 1'b0;
    end
  end

  assign bus.lcd_data = r_data;
  assign bus.lcd_rs   = r_rs;
  assign bus.lcd_en   = (r_state == S_INIT || r_state == S_UPD) && (r_phase == P_EN);
  assign bus.lcd_rw   = 1'b0;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);

endmodule

// File: tb/tb_lcd_number_writer.sv
// Directed bench for lcd_number_writer with short timing parameters.
// A negedge monitor logs every byte latched on a falling lcd_en, together with the
// enable-high length and the enable-low gap before each rising edge.
module tb_lcd_number_writer;
  localparam int PWR_WAIT  = 20;
  localparam int EN_CYCLES = 4;
  localparam int CMD_WAIT  = 10;
  localparam int CLR_WAIT  = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_number_writer_if bus();

  lcd_number_writer #(
    .PWR_WAIT (PWR_WAIT),
    .EN_CYCLES(EN_CYCLES),
    .CMD_WAIT (CMD_WAIT),
    .CLR_WAIT (CLR_WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] q_byte[$];
  logic [8:0] q_exp[$];
  int q_high[$];
  int q_low[$];
  int high_cnt = 0;
  int low_cnt = 0;
  int done_cnt = 0;
  logic en_prev = 1'b0;

  // Monitor: capture {rs,data} at each falling lcd_en, the enable-high length and the low gap before each rise.
  always @(negedge clk) begin
    if (bus.lcd_en === 1'b1) begin
      if (!en_prev) begin
        q_low.push_back(low_cnt);
        high_cnt = 0;
      end
      high_cnt++;
    end else begin
      if (en_prev) begin
        q_byte.push_back({bus.lcd_rs, bus.lcd_data});
        q_high.push_back(high_cnt);
        low_cnt = 0;
      end
      low_cnt++;
    end
    en_prev = (bus.lcd_en === 1'b1);
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_val(input logic s, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d, input logic [3:0] e);
    bus.sinal = s;
    bus.dezena_milhar = a;
    bus.milhar = b;
    bus.centena = c;
    bus.dezena = d;
    bus.unidade = e;
  endtask

  // Expected update: clear command, then sign and five digit characters (hand-computed ASCII).
  task automatic exp_update(input logic [7:0] sg, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d, input logic [7:0] e);
    q_exp.push_back({1'b0, 8'h01});
    q_exp.push_back({1'b1, sg});
    q_exp.push_back({1'b1, a});
    q_exp.push_back({1'b1, b});
    q_exp.push_back({1'b1, c});
    q_exp.push_back({1'b1, d});
    q_exp.push_back({1'b1, e});
  endtask

  task automatic exp_init();
    q_exp.push_back({1'b0, 8'h38});
    q_exp.push_back({1'b0, 8'h0C});
    q_exp.push_back({1'b0, 8'h06});
    q_exp.push_back({1'b0, 8'h01});
  endtask

  task automatic clr_log();
    q_byte.delete();
    q_high.delete();
    q_low.delete();
  endtask

  task automatic chk_seq(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_len"}, q_byte.size(), q_exp.size());
    for (int i = 0; i < q_exp.size() && i < q_byte.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), q_byte[i], q_exp[i]);
    foreach (q_high[i]) if (q_high[i] != EN_CYCLES) bad++;
    chk({tag, "_en_high_len"}, bad, 0);
    q_exp.delete();
    q_byte.delete();
    q_high.delete();
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int i = 0; i < 3000 && done_cnt < target; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk(tag, done_cnt, target);
  endtask

  task automatic wait_en_byte(input string tag, input logic [8:0] b);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      #1;
      hit = (bus.lcd_en === 1'b1) && ({bus.lcd_rs, bus.lcd_data} === b);
    end
    chk(tag, 32'(hit), 1);
  endtask

  initial begin
    int base;
    int busy_cycles;
    rst_n = 1'b0;
    bus.refresh = 1'b0;
    set_val(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data", bus.lcd_data, 8'h00);
    chk("rst_rs", bus.lcd_rs, 1'b0);
    chk("rst_en", bus.lcd_en, 1'b0);
    chk("rst_rw", bus.lcd_rw, 1'b0);
    chk("rst_busy", bus.busy, 1'b1);
    chk("rst_done", bus.done, 1'b0);
    clr_log();

    // Case 1: power-up with +00000. A refresh pulse during the power wait is dropped.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    bus.refresh = 1'b1;
    @(negedge clk);
    bus.refresh = 1'b0;
    wait_done("c1_done", 1);
    chk("c1_busy_idle", bus.busy, 1'b0);
    repeat (100) @(negedge clk);
    #1;
    chk("c1_single_done", done_cnt, 1);
    chk("c1_rw", bus.lcd_rw, 1'b0);
    exp_init();
    exp_update(8'h2B, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30);
    chk_seq("c1");
    clr_log();

    // Case 2: -32768. The low gap from a fall to the next rise is WAIT plus one setup cycle.
    set_val(1'b1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd8);
    wait_done("c2_done", 2);
    exp_update(8'h2D, 8'h33, 8'h32, 8'h37, 8'h36, 8'h38);
    chk("c2_gap_cnt", q_low.size(), 7);
    if (q_low.size() == 7) begin
      chk("c2_gap_after_clr", q_low[1], CLR_WAIT + 1);
      base = 0;
      for (int i = 2; i < 7; i++) if (q_low[i] != CMD_WAIT + 1) base++;
      chk("c2_gap_after_chr", base, 0);
    end
    chk_seq("c2");
    clr_log();

    // Case 3: the value is held constant, so the display must stay quiet.
    base = done_cnt;
    busy_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (bus.busy !== 1'b0) busy_cycles++;
    end
    chk("c3_no_bytes", q_byte.size(), 0);
    chk("c3_no_done", done_cnt, base);
    chk("c3_busy_cycles", busy_cycles, 0);
    clr_log();

    // Case 4: the value changes during the hundreds write. The update in flight keeps the old digits.
    base = done_cnt;
    set_val(1'b0, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5);
    wait_en_byte("c4_centena_seen", {1'b1, 8'h37});
    set_val(1'b0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2);
    wait_done("c4_done", base + 2);
    exp_update(8'h2B, 8'h39, 8'h38, 8'h37, 8'h36, 8'h35);
    exp_update(8'h2B, 8'h30, 8'h30, 8'h30, 8'h34, 8'h32);
    chk_seq("c4");
    clr_log();

    // Case 5a: a non-decimal units digit is shown as '?'.
    base = done_cnt;
    set_val(1'b0, 4'd0, 4'd0, 4'd0, 4'd4, 4'hC);
    wait_done("c5_done", base + 1);
    exp_update(8'h2B, 8'h30, 8'h30, 8'h30, 8'h34, 8'h3F);
    chk_seq("c5a");
    clr_log();

    // Case 5b: two back-to-back refresh pulses in IDLE cause exactly one rewrite.
    base = done_cnt;
    bus.refresh = 1'b1;
    repeat (2) @(negedge clk);
    bus.refresh = 1'b0;
    wait_done("c5b_done", base + 1);
    repeat (400) @(negedge clk);
    #1;
    chk("c5b_one_rewrite", done_cnt, base + 1);
    exp_update(8'h2B, 8'h30, 8'h30, 8'h30, 8'h34, 8'h3F);
    chk_seq("c5b");
    clr_log();

    // Case 6: reset during a digit's enable-high phase, then a full replay.
    set_val(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    wait_en_byte("c6_digit_seen", {1'b1, 8'h30});
    #2;
    rst_n = 1'b0;
    #1;
    chk("c6_en_async", bus.lcd_en, 1'b0);
    chk("c6_data_rst", bus.lcd_data, 8'h00);
    chk("c6_busy_rst", bus.busy, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    clr_log();
    base = done_cnt;
    rst_n = 1'b1;
    wait_done("c6_done", base + 1);
    chk("c6_busy_idle", bus.busy, 1'b0);
    exp_init();
    exp_update(8'h2B, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30);
    chk_seq("c6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
